// File: rtl/piano_pkg.sv
// Shared definitions for the voice allocator: sizes, index/age types,
// the scheduler state encoding and a saturating age helper.
package piano_pkg;

    localparam int NUM_KEYS   = 13;
    localparam int NUM_VOICES = 4;
    localparam int KEY_W      = 4;
    localparam int AGE_W      = 8;
    localparam int VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef logic [KEY_W-1:0]   key_idx_t;
    typedef logic [AGE_W-1:0]   age_t;
    typedef logic [VOICE_W-1:0] voice_idx_t;

    typedef enum logic {
        SCAN  = 1'b0,
        MUTED = 1'b1
    } state_e;

    localparam key_idx_t LAST_KEY = key_idx_t'(NUM_KEYS - 1);
    localparam age_t     AGE_MAX  = '1;

    // Age advances by one per sweep and sticks at its maximum.
    function automatic age_t age_inc(input age_t a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice picker: lowest-index free voice, and the oldest
// voice (highest age, ties resolved to the lowest index) as steal victim.
module voice_select
    import piano_pkg::*;
(
    input  logic [NUM_VOICES-1:0]            voice_active,
    input  logic [NUM_VOICES-1:0][AGE_W-1:0] ages,
    output logic                             free_found,
    output voice_idx_t                       free_idx,
    output voice_idx_t                       oldest_idx
);

    age_t oldest_age;

    // Priority scan from voice 0 upwards; strict compare keeps ties at the lower index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        oldest_idx = '0;
        oldest_age = ages[0];
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!voice_active[v] && !free_found) begin
                free_found = 1'b1;
                free_idx   = voice_idx_t'(v);
            end
        end
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (ages[v] > oldest_age) begin
                oldest_age = ages[v];
                oldest_idx = voice_idx_t'(v);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: sweeps keys_held one key per cycle, binds newly held
// keys to free voices, releases voices whose key went up, and pulses
// voice_start / voice_stop for the tone generators.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when all
// voices are busy; otherwise such a press is ignored until a voice frees.
//
// Interface timing: all outputs are registered. voice_start/voice_stop are
// single-cycle pulses that appear the cycle after the key's index is scanned;
// voice_active/voice_key hold steady between events.
module voice_allocator
    import piano_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_KEYS-1:0]           keys_held,
    input  logic                          mute,
    output logic [NUM_VOICES-1:0]         voice_active,
    output logic [NUM_VOICES*KEY_W-1:0]   voice_key,
    output logic [NUM_VOICES-1:0]         voice_start,
    output logic [NUM_VOICES-1:0]         voice_stop
);

    state_e                           state_q, state_d;
    key_idx_t                         scan_idx_q, scan_idx_d;
    logic [NUM_VOICES-1:0]            active_q, active_d;
    logic [NUM_VOICES-1:0]            start_q, start_d;
    logic [NUM_VOICES-1:0]            stop_q, stop_d;
    logic [NUM_VOICES-1:0][KEY_W-1:0] key_q, key_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
    // Key -> voice map: which keys currently own a voice, and which one.
    logic [NUM_KEYS-1:0]              map_valid_q, map_valid_d;
    logic [NUM_KEYS-1:0][VOICE_W-1:0] map_voice_q, map_voice_d;

    logic       free_found;
    voice_idx_t free_idx;
    voice_idx_t oldest_idx;
    logic       steal_ok;
    logic       key_down;
    logic       key_owned;
    logic       last_key;
    voice_idx_t alloc_tgt;
    voice_idx_t rel_voice;

    voice_select u_voice_select (
        .voice_active (active_q),
        .ages         (age_q),
        .free_found   (free_found),
        .free_idx     (free_idx),
        .oldest_idx   (oldest_idx)
    );

`ifdef VOICE_STEAL_EN
    assign steal_ok = 1'b1;
`else
    assign steal_ok = 1'b0;
`endif

    assign key_down  = keys_held[scan_idx_q];
    assign key_owned = map_valid_q[scan_idx_q];
    assign rel_voice = map_voice_q[scan_idx_q];
    assign last_key  = (scan_idx_q == LAST_KEY);
    // With no free voice the target is the steal victim (only used when stealing).
    assign alloc_tgt = free_found ? free_idx : oldest_idx;

    // Next-state logic: mute handling, sweep advance, ageing, allocate/release.
    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        active_d    = active_q;
        key_d       = key_q;
        age_d       = age_q;
        start_d     = '0;
        stop_d      = '0;
        map_valid_d = map_valid_q;
        map_voice_d = map_voice_q;

        case (state_q)
            SCAN: begin
                if (mute) begin
                    // Mute beats any allocation this cycle; silence everything at once.
                    state_d     = MUTED;
                    scan_idx_d  = '0;
                    stop_d      = active_q;
                    active_d    = '0;
                    map_valid_d = '0;
                end else begin
                    if (last_key) begin
                        scan_idx_d = '0;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (active_q[v]) begin
                                age_d[v] = age_inc(age_q[v]);
                            end
                        end
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end

                    if (key_down && !key_owned) begin
                        if (free_found || steal_ok) begin
                            if (!free_found) begin
                                // Stealing: the victim's key loses its binding and re-requests later.
                                stop_d[alloc_tgt]             = 1'b1;
                                map_valid_d[key_q[alloc_tgt]] = 1'b0;
                            end
                            active_d[alloc_tgt]     = 1'b1;
                            key_d[alloc_tgt]        = scan_idx_q;
                            age_d[alloc_tgt]        = '0;
                            start_d[alloc_tgt]      = 1'b1;
                            map_valid_d[scan_idx_q] = 1'b1;
                            map_voice_d[scan_idx_q] = alloc_tgt;
                        end
                    end else if (!key_down && key_owned) begin
                        // voice_key is left as-is so the generator can finish its note.
                        active_d[rel_voice]     = 1'b0;
                        stop_d[rel_voice]       = 1'b1;
                        map_valid_d[scan_idx_q] = 1'b0;
                    end
                end
            end

            MUTED: begin
                if (!mute) begin
                    state_d    = SCAN;
                    scan_idx_d = '0;
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State and output registers; reset silently discards everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            scan_idx_q  <= '0;
            active_q    <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            key_q       <= '0;
            age_q       <= '0;
            map_valid_q <= '0;
            map_voice_q <= '0;
        end else begin
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            active_q    <= active_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            key_q       <= key_d;
            age_q       <= age_d;
            map_valid_q <= map_valid_d;
            map_voice_q <= map_voice_d;
        end
    end

    assign voice_active = active_q;
    assign voice_key    = key_q;
    assign voice_start  = start_q;
    assign voice_stop   = stop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random key/mute/reset
// traffic, every cycle compared against a behavioural key/voice model.
module tb_voice_allocator;

    localparam int NK = 13;
    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mute;
    logic [12:0] keys_held;
    logic [3:0]  voice_active;
    logic [15:0] voice_key;
    logic [3:0]  voice_start;
    logic [3:0]  voice_stop;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which key each voice plays, how old it is, who owns each key.
    int m_scan;
    bit m_muted;
    bit m_act   [NV];
    int m_key   [NV];
    int m_age   [NV];
    bit m_start [NV];
    bit m_stop  [NV];
    int m_owner [NK];

    always #5 clk = ~clk;

    voice_allocator dut (
        .clk          (clk),
        .reset        (reset),
        .keys_held    (keys_held),
        .mute         (mute),
        .voice_active (voice_active),
        .voice_key    (voice_key),
        .voice_start  (voice_start),
        .voice_stop   (voice_stop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_scan  = 0;
        m_muted = 0;
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 0; m_key[v] = 0; m_age[v] = 0; m_start[v] = 0; m_stop[v] = 0;
        end
        for (int k = 0; k < NK; k++) m_owner[k] = -1;
    endfunction

    function automatic void model_assign(input int v, input int k);
        m_act[v]   = 1;
        m_key[v]   = k;
        m_age[v]   = 0;
        m_start[v] = 1;
        m_owner[k] = v;
    endfunction

    // One clock of the model given the inputs presented before that edge.
    function automatic void model_step(input bit rst, input bit mu, input bit [12:0] keys);
        int k;
        int v;
        for (int i = 0; i < NV; i++) begin m_start[i] = 0; m_stop[i] = 0; end
        if (rst) begin model_clear(); return; end
        if (m_muted) begin
            if (!mu) begin m_muted = 0; m_scan = 0; end
            return;
        end
        if (mu) begin
            for (int i = 0; i < NV; i++) if (m_act[i]) begin m_stop[i] = 1; m_act[i] = 0; end
            for (int i = 0; i < NK; i++) m_owner[i] = -1;
            m_muted = 1;
            m_scan  = 0;
            return;
        end
        k = m_scan;
        if (k == NK - 1) begin
            for (int i = 0; i < NV; i++) if (m_act[i] && m_age[i] < 255) m_age[i]++;
            m_scan = 0;
        end else begin
            m_scan = k + 1;
        end
        if (keys[k] && m_owner[k] < 0) begin
            v = -1;
            for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) v = i;
            if (v >= 0) begin
                model_assign(v, k);
            end else begin
`ifdef VOICE_STEAL_EN
                v = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[v]) v = i;
                m_owner[m_key[v]] = -1;
                m_stop[v] = 1;
                model_assign(v, k);
`endif
            end
        end else if (!keys[k] && m_owner[k] >= 0) begin
            v = m_owner[k];
            m_act[v]   = 0;
            m_stop[v]  = 1;
            m_owner[k] = -1;
        end
    endfunction

    task automatic compare_model();
        logic [3:0]  e_act, e_start, e_stop;
        logic [15:0] e_key;
        for (int v = 0; v < NV; v++) begin
            e_act[v]         = m_act[v];
            e_start[v]       = m_start[v];
            e_stop[v]        = m_stop[v];
            e_key[v*4 +: 4]  = 4'(m_key[v]);
        end
        check("active", voice_active, e_act);
        check("key",    voice_key,    e_key);
        check("start",  voice_start,  e_start);
        check("stop",   voice_stop,   e_stop);
    endtask

    // Advance one clock: model sees the current inputs, DUT is sampled at the next negedge.
    task automatic cycle();
        model_step(reset, mute, keys_held);
        @(negedge clk);
        compare_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_start(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            if (voice_start != 4'b0) seen = 1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_stop(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            if (voice_stop != 4'b0) seen = 1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int pulses;
        model_clear();
        reset = 1'b1; mute = 1'b0; keys_held = '0;
        @(negedge clk);
        run(2);
        check("rst_active", voice_active, 4'b0);
        check("rst_key",    voice_key,    16'h0);
        check("rst_start",  voice_start,  4'b0);
        check("rst_stop",   voice_stop,   4'b0);

        // Single key press lands on voice 0.
        reset = 1'b0; keys_held = 13'h0001;
        wait_start("first_start_seen", 14);
        check("first_start",  voice_start, 4'b0001);
        check("first_stop",   voice_stop,  4'b0000);
        check("first_key0",   voice_key[3:0], 4'd0);
        check("first_active", voice_active, 4'b0001);

        // Keys 0,2,4,6 fill voices 0..3 in order.
        keys_held = 13'h0055;
        run(14);
        check("fill_keys",   voice_key,    16'h6420);
        check("fill_active", voice_active, 4'b1111);

        // Release key 2 frees voice 1.
        keys_held = 13'h0051;
        wait_stop("rel_stop_seen", 14);
        check("rel_stop",   voice_stop,   4'b0010);
        check("rel_active", voice_active, 4'b1101);
        keys_held = 13'h0055;
        run(14);
        check("refill_active", voice_active, 4'b1111);

        // Press key 9 with every voice busy.
        keys_held = 13'h0255;
`ifdef VOICE_STEAL_EN
        wait_start("steal_seen", 14);
        check("steal_start", voice_start, 4'b0001);
        check("steal_stop",  voice_stop,  4'b0001);
        check("steal_key0",  voice_key[3:0], 4'd9);
`else
        pulses = 0;
        for (int i = 0; i < 26; i++) begin
            cycle();
            if (voice_start != 0 || voice_stop != 0) pulses++;
        end
        check("busy_pulses", 32'(pulses), 32'd0);
        keys_held = 13'h0245;
        wait_stop("free2_seen", 14);
        check("free2_stop", voice_stop, 4'b0100);
        wait_start("k9_seen", 26);
        check("k9_start", voice_start, 4'b0100);
        check("k9_key2",  voice_key[11:8], 4'd9);
`endif

        // Mute with three voices sounding.
        keys_held = '0;
        run(28);
        check("drain_active", voice_active, 4'b0);
        keys_held = 13'h0007;
        run(14);
        check("pre_mute_active", voice_active, 4'b0111);
        mute = 1'b1;
        cycle();
        check("mute_stop",   voice_stop,   4'b0111);
        check("mute_start",  voice_start,  4'b0000);
        cycle();
        check("mute_active", voice_active, 4'b0000);
        run(3);
        mute = 1'b0;
        run(2);
        check("unmute_v0", voice_start, 4'b0001);
        check("unmute_k0", voice_key[3:0], 4'd0);
        cycle();
        check("unmute_v1", voice_start, 4'b0010);
        check("unmute_k1", voice_key[7:4], 4'd1);
        cycle();
        check("unmute_v2", voice_start, 4'b0100);
        check("unmute_k2", voice_key[11:8], 4'd2);

        // Reset mid-sweep with two voices active.
        keys_held = 13'h0003;
        run(14);
        check("pre_rst_active", voice_active, 4'b0011);
        run(5);
        reset = 1'b1;
        cycle();
        check("mid_rst_active", voice_active, 4'b0);
        check("mid_rst_stop",   voice_stop,   4'b0);
        check("mid_rst_key",    voice_key,    16'h0);
        reset = 1'b0;
        cycle();
        check("post_rst_v0", voice_start, 4'b0001);
        cycle();
        check("post_rst_v1", voice_start, 4'b0010);
        check("post_rst_k1", voice_key[7:4], 4'd1);

        // Age saturation: key 0 ages past 255 sweeps, key 1 ages 50 sweeps.
        keys_held = '0;
        run(28);
        keys_held = 13'h0001;
        run(300 * NK);
        keys_held = 13'h0003;
        run(50 * NK);
        keys_held = 13'h000F;
        run(14);
        check("sat_active", voice_active, 4'b1111);
        keys_held = 13'h002F;
`ifdef VOICE_STEAL_EN
        wait_start("sat_steal_seen", 14);
        check("sat_steal_start", voice_start, 4'b0001);
        check("sat_steal_key0",  voice_key[3:0], 4'd5);
`else
        run(26);
        check("sat_no_alloc", voice_active, 4'b1111);
`endif

        // Random traffic.
        keys_held = '0;
        run(28);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) keys_held[$urandom_range(0, NK - 1)] ^= 1'b1;
            if (mute) mute = ($urandom_range(0, 3) != 0);
            else      mute = ($urandom_range(0, 199) == 0);
            reset = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0; mute = 1'b0;
        run(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
